// File: rtl/riscy_data_mem_slave_if.sv
// Data-port bus between the RISCY core (master) and its memory slave.
//   data_req    master -> slave  request
//   data_gnt    slave  -> master request accepted
//   data_rvalid slave  -> master response valid, one cycle after grant
//   data_we     master -> slave  1 = store, 0 = load
//   data_be     master -> slave  byte enables
//   data_addr   master -> slave  byte address
//   data_wdata  master -> slave  store data
//   data_rdata  slave  -> master load data, valid with data_rvalid
interface riscy_data_mem_slave_if;
    logic        data_req;
    logic        data_gnt;
    logic        data_rvalid;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata
    );
endinterface

// File: rtl/riscy_data_mem_slave.sv
// Data-side memory slave for the RISCY core testbench.
// Answers req/gnt/rvalid handshakes from a word-addressed memory, applies
// byte-enabled stores, publishes each accepted store as a one-cycle record
// and offers a full-word preload port for the testbench.
// Ports:
//   clk, rst_ni      clock (posedge), asynchronous active-low reset
//   bus              data port (slave modport): req/gnt/rvalid, we, be,
//                    addr, wdata, rdata
//   tb_we_i/addr/wdata   preload strobe, byte address, full word
//   store_valid_o    store record valid, coincides with that store's rvalid
//   store_addr_o/wdata_o/be_o   captured store address, data, byte enables
//   oob_err_o        sticky flag: an out-of-range bus access was granted
module riscy_data_mem_slave #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int unsigned GNT_DELAY = 0,
    parameter logic [31:0] OOB_RDATA = 32'hDEADBEEF
) (
    input  logic                          clk,
    input  logic                          rst_ni,
    riscy_data_mem_slave_if.slave         bus,
    input  logic                          tb_we_i,
    input  logic [31:0]                   tb_addr_i,
    input  logic [31:0]                   tb_wdata_i,
    output logic                          store_valid_o,
    output logic [31:0]                   store_addr_o,
    output logic [31:0]                   store_wdata_o,
    output logic [3:0]                    store_be_o,
    output logic                          oob_err_o
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(GNT_DELAY + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GNT_DELAY);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       mem [MEM_WORDS];

    logic [31:0]       bus_off;
    logic [31:0]       tb_off;
    logic              bus_in_range;
    logic              tb_in_range;
    logic [IDX_W-1:0]  bus_idx;
    logic [IDX_W-1:0]  tb_idx;
    logic              gnt;
    logic              unused_low_bits;

    // Word index is (addr - base) >> 2; the byte offset bits are dropped.
    assign bus_off      = bus.data_addr - ADDR_BASE;
    assign tb_off       = tb_addr_i - ADDR_BASE;
    assign bus_in_range = (bus.data_addr >= ADDR_BASE) && ({2'b00, bus_off[31:2]} < MEM_WORDS);
    assign tb_in_range  = (tb_addr_i >= ADDR_BASE) && ({2'b00, tb_off[31:2]} < MEM_WORDS);
    assign bus_idx      = bus_off[IDX_W+1:2];
    assign tb_idx       = tb_off[IDX_W+1:2];
    assign unused_low_bits = ^{bus_off[1:0], tb_off[1:0]};

    // Grant is combinational so a zero-delay slave accepts in the request cycle.
    always_comb begin
        gnt = 1'b0;
        if (bus.data_req) begin
            case (state)
                IDLE:    gnt = (GNT_DELAY == 0);
                WAIT:    gnt = (cnt == CNT_MAX);
                default: gnt = 1'b0;
            endcase
        end
    end

    assign bus.data_gnt = gnt;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.data_req && (GNT_DELAY != 0)) begin
                        cnt   <= CNT_W'(1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // Dropping req abandons the request; the next one waits the full delay.
                    if (!bus.data_req || (cnt == CNT_MAX)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response path: one rvalid per grant, on the next edge. The memory read
    // here sees the pre-edge contents, giving read-before-write behaviour.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.data_rvalid <= 1'b0;
            bus.data_rdata  <= '0;
            store_valid_o   <= 1'b0;
            store_addr_o    <= '0;
            store_wdata_o   <= '0;
            store_be_o      <= '0;
            oob_err_o       <= 1'b0;
        end else begin
            bus.data_rvalid <= gnt;
            store_valid_o   <= gnt && bus.data_we;
            if (gnt) begin
                if (bus.data_we) begin
                    bus.data_rdata <= '0;
                    store_addr_o   <= bus.data_addr;
                    store_wdata_o  <= bus.data_wdata;
                    store_be_o     <= bus.data_be;
                end else if (bus_in_range) begin
                    bus.data_rdata <= mem[bus_idx];
                end else begin
                    bus.data_rdata <= OOB_RDATA;
                end
                if (!bus_in_range) begin
                    oob_err_o <= 1'b1;
                end
            end
        end
    end

    // Memory is not reset. Preload is applied first so a same-cycle bus
    // store to the same word overrides it on its enabled bytes.
    always_ff @(posedge clk) begin
        if (tb_we_i && tb_in_range) begin
            mem[tb_idx] <= tb_wdata_i;
        end
        if (gnt && bus.data_we && bus_in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus.data_be[b]) begin
                    mem[bus_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
